// File: rtl/gsu_cache_fill.sv
// Instruction-cache fill engine: serves core fetches from a 512-byte window
// of cached ROM, filling whole 16-byte lines on a miss or reading ROM directly.
module gsu_cache_fill #(
  parameter int LINE_BYTES = 16
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic [7:0]  pbr,
  input  logic [15:0] cbr,
  input  logic        fetch_req,
  input  logic        cache_flush,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [8:0]  cache_addra,
  output logic [7:0]  cache_dina,
  output logic        cache_wea,
  input  logic [7:0]  cache_douta,
  output logic [31:0] line_valid,
  output logic        fill_busy
);

  typedef enum logic [2:0] {
    IDLE, HIT_RD, HIT_CAP, FILL_REQ, FILL_WAIT, DIRECT_WAIT, ACK
  } state_e;

  localparam logic [3:0] LastByte = 4'(LINE_BYTES - 1);

  state_e      state_q;
  logic [4:0]  line_q;
  logic [3:0]  byte_q;
  logic [3:0]  i_q;
  logic        abort_q;
  logic        fetch_ack_q;
  logic [7:0]  fetch_data_q;
  logic        rom_req_q;
  logic [23:0] rom_addr_q;
  logic [8:0]  cache_addra_q;
  logic [7:0]  cache_dina_q;
  logic        cache_wea_q;
  logic [31:0] line_valid_q;

  logic [15:0] offset;
  logic        inWindow;
  logic [15:0] fillAddr;
  logic        abortNow;
  logic [31:0] validSeen;

  assign offset   = pc - cbr;
  assign inWindow = (offset[15:9] == 7'd0);
  assign fillAddr = cbr + {7'd0, line_q, 4'h0} + {12'd0, i_q};
  // A flush arriving in the same cycle as the final handshake still aborts the fill.
  assign abortNow = abort_q | cache_flush;
  // A flush coinciding with a new request is applied before the hit lookup.
  assign validSeen = cache_flush ? 32'd0 : line_valid_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      byte_q        <= '0;
      i_q           <= '0;
      abort_q       <= 1'b0;
      fetch_ack_q   <= 1'b0;
      fetch_data_q  <= '0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= '0;
      cache_addra_q <= '0;
      cache_dina_q  <= '0;
      cache_wea_q   <= 1'b0;
      line_valid_q  <= '0;
    end else begin
      cache_wea_q <= 1'b0;
      fetch_ack_q <= 1'b0;
      if (cache_flush) line_valid_q <= '0;
      if (cache_flush && (state_q == FILL_REQ || state_q == FILL_WAIT)) abort_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            line_q <= offset[8:4];
            byte_q <= offset[3:0];
            if (!inWindow) begin
              rom_req_q  <= 1'b1;
              rom_addr_q <= {pbr, pc};
              state_q    <= DIRECT_WAIT;
            end else if (validSeen[offset[8:4]]) begin
              cache_addra_q <= offset[8:0];
              state_q       <= HIT_RD;
            end else begin
              i_q     <= '0;
              state_q <= FILL_REQ;
            end
          end
        end
        HIT_RD: state_q <= HIT_CAP;
        HIT_CAP: begin
          fetch_data_q <= cache_douta;
          fetch_ack_q  <= 1'b1;
          state_q      <= ACK;
        end
        FILL_REQ: begin
          rom_req_q  <= 1'b1;
          rom_addr_q <= {pbr, fillAddr};
          state_q    <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (rom_ack) begin
            rom_req_q     <= 1'b0;
            cache_addra_q <= {line_q, i_q};
            cache_dina_q  <= rom_data;
            cache_wea_q   <= 1'b1;
            if (i_q == byte_q) fetch_data_q <= rom_data;
            if (abortNow) begin
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else if (i_q != LastByte) begin
              i_q     <= i_q + 4'd1;
              state_q <= FILL_REQ;
            end else begin
              line_valid_q[line_q] <= 1'b1;
              fetch_ack_q          <= 1'b1;
              state_q              <= ACK;
            end
          end
        end
        DIRECT_WAIT: begin
          if (rom_ack) begin
            rom_req_q    <= 1'b0;
            fetch_data_q <= rom_data;
            fetch_ack_q  <= 1'b1;
            state_q      <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_ack   = fetch_ack_q;
  assign fetch_data  = fetch_data_q;
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign cache_addra = cache_addra_q;
  assign cache_dina  = cache_dina_q;
  assign cache_wea   = cache_wea_q;
  assign line_valid  = line_valid_q;
  assign fill_busy   = (state_q == FILL_REQ) || (state_q == FILL_WAIT) || (state_q == DIRECT_WAIT);

endmodule
